// File: rtl/round_control.sv
// -----------------------------------------------------------------------------
// round_control
// Round/score sequencer for a two-player sword duel. It watches the hit,
// clash and board-edge flags from the collision stage. It decides when
// players may move, when they are knocked back, when they respawn, and when
// the game is won.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   frame_tick   one-cycle pulse per video frame
//   start        one-cycle pulse: begin / restart a game from any state
//   dead_L/R     level hit flags (left / right player killed)
//   collision    level sword-clash flag
//   pos_reset    level flag: a player reached a board edge
//   play_enable  high only in PLAY (gates player movement)
//   knockback    high only in KNOCKBACK
//   respawn      one-cycle pulse: reload player positions
//   score_L/R    kill counters, saturating at WIN_SCORE
//   game_over    high only in GAME_OVER
//   winner_L     valid while game_over, 1 = left player won
// -----------------------------------------------------------------------------
module round_control #(
   parameter int RESPAWN_FRAMES = 120,  // frames spent in DEAD_WAIT (1..256)
   parameter int KNOCK_FRAMES   = 8,    // frames spent in KNOCKBACK (1..256)
   parameter int WIN_SCORE      = 5     // kills needed to win (1..15)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       dead_L,
   input  logic       dead_R,
   input  logic       collision,
   input  logic       pos_reset,
   output logic       play_enable,
   output logic       knockback,
   output logic       respawn,
   output logic [3:0] score_L,
   output logic [3:0] score_R,
   output logic       game_over,
   output logic       winner_L
);

   typedef enum logic [2:0] {
      IDLE,
      PLAY,
      KNOCKBACK,
      DEAD_WAIT,
      ROUND_RESET,
      GAME_OVER
   } state_t;

   // Terminal counts: the wait ends on the tick that arrives while the
   // counter already holds N-1, so exactly N ticks are spent in the state.
   localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
   localparam logic [7:0] KNOCK_LAST   = 8'(KNOCK_FRAMES - 1);
   localparam logic [3:0] WIN          = 4'(WIN_SCORE);

   state_t     state_reg, state_next;
   logic [7:0] cnt_reg, cnt_next;
   logic [3:0] score_l_reg, score_l_next;
   logic [3:0] score_r_reg, score_r_next;
   logic       respawn_reg, respawn_next;

   // Previous-cycle copies of the level flags for rising-edge detection
   logic dead_l_prev_reg, dead_r_prev_reg, collision_prev_reg, pos_reset_prev_reg;

   logic dead_l_ev, dead_r_ev, collision_ev, pos_reset_ev;
   logic [3:0] score_l_inc, score_r_inc;

   assign dead_l_ev    = dead_L    & ~dead_l_prev_reg;
   assign dead_r_ev    = dead_R    & ~dead_r_prev_reg;
   assign collision_ev = collision & ~collision_prev_reg;
   assign pos_reset_ev = pos_reset & ~pos_reset_prev_reg;

   // Saturating increments; a score never passes WIN_SCORE
   assign score_l_inc = (score_l_reg >= WIN) ? WIN : score_l_reg + 4'd1;
   assign score_r_inc = (score_r_reg >= WIN) ? WIN : score_r_reg + 4'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg          <= IDLE;
         cnt_reg            <= 8'd0;
         score_l_reg        <= 4'd0;
         score_r_reg        <= 4'd0;
         respawn_reg        <= 1'b0;
         dead_l_prev_reg    <= 1'b0;
         dead_r_prev_reg    <= 1'b0;
         collision_prev_reg <= 1'b0;
         pos_reset_prev_reg <= 1'b0;
      end else begin
         state_reg          <= state_next;
         cnt_reg            <= cnt_next;
         score_l_reg        <= score_l_next;
         score_r_reg        <= score_r_next;
         respawn_reg        <= respawn_next;
         dead_l_prev_reg    <= dead_L;
         dead_r_prev_reg    <= dead_R;
         collision_prev_reg <= collision;
         pos_reset_prev_reg <= pos_reset;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      score_l_next = score_l_reg;
      score_r_next = score_r_reg;
      respawn_next = 1'b0;

      case (state_reg)
         IDLE: ;  // only start leaves IDLE (handled below)

         PLAY: begin
            // One event per cycle: edge > death > clash; the rest is dropped
            if (pos_reset_ev) begin
               state_next = ROUND_RESET;
            end else if (dead_l_ev && dead_r_ev) begin
               state_next = DEAD_WAIT;  // double kill: nobody scores
            end else if (dead_r_ev) begin
               score_l_next = score_l_inc;
               state_next   = (score_l_inc == WIN || score_r_reg == WIN) ? GAME_OVER : DEAD_WAIT;
            end else if (dead_l_ev) begin
               score_r_next = score_r_inc;
               state_next   = (score_r_inc == WIN || score_l_reg == WIN) ? GAME_OVER : DEAD_WAIT;
            end else if (collision_ev) begin
               state_next = KNOCKBACK;
            end
         end

         KNOCKBACK: begin
            if (frame_tick) begin
               if (cnt_reg == KNOCK_LAST) state_next = PLAY;
               else if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
            end
         end

         DEAD_WAIT: begin
            if (frame_tick) begin
               if (cnt_reg == RESPAWN_LAST) begin
                  state_next   = PLAY;
                  respawn_next = 1'b1;
               end else if (cnt_reg != 8'hFF) begin
                  cnt_next = cnt_reg + 8'd1;
               end
            end
         end

         ROUND_RESET: begin
            state_next   = PLAY;
            respawn_next = 1'b1;
         end

         GAME_OVER: ;  // held until start or reset

         default: state_next = IDLE;
      endcase

      // start wins over every event and works from any state
      if (start) begin
         state_next   = PLAY;
         score_l_next = 4'd0;
         score_r_next = 4'd0;
         respawn_next = 1'b1;
      end

      // Every state entry begins with a fresh frame count
      if (state_next != state_reg) cnt_next = 8'd0;
   end

   assign play_enable = (state_reg == PLAY);
   assign knockback   = (state_reg == KNOCKBACK);
   assign game_over   = (state_reg == GAME_OVER);
   assign winner_L    = (state_reg == GAME_OVER) && (score_l_reg == WIN);
   assign respawn     = respawn_reg;
   assign score_L     = score_l_reg;
   assign score_R     = score_r_reg;

endmodule

// File: tb/tb_round_control.sv
// -----------------------------------------------------------------------------
// tb_round_control
// Directed, table-driven bench for round_control with default parameters
// (RESPAWN_FRAMES=120, KNOCK_FRAMES=8, WIN_SCORE=5). Each vector drives one
// input pattern for 'reps' cycles and checks the outputs after every cycle.
// The long win sequence and the reset/restart corners are hand-written.
// -----------------------------------------------------------------------------
module tb_round_control;

   logic       clk = 1'b0;
   logic       reset, frame_tick, start, dead_L, dead_R, collision, pos_reset;
   logic       play_enable, knockback, respawn, game_over, winner_L;
   logic [3:0] score_L, score_R;

   int errors = 0;
   int checks = 0;

   round_control dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .start       (start),
      .dead_L      (dead_L),
      .dead_R      (dead_R),
      .collision   (collision),
      .pos_reset   (pos_reset),
      .play_enable (play_enable),
      .knockback   (knockback),
      .respawn     (respawn),
      .score_L     (score_L),
      .score_R     (score_R),
      .game_over   (game_over),
      .winner_L    (winner_L)
   );

   always #5 clk = ~clk;

   // Input pattern bits: {reset, start, dead_L, dead_R, collision, pos_reset, frame_tick}
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] RST  = 7'b1000000;
   localparam logic [6:0] ST   = 7'b0100000;
   localparam logic [6:0] DL   = 7'b0010000;
   localparam logic [6:0] DR   = 7'b0001000;
   localparam logic [6:0] COL  = 7'b0000100;
   localparam logic [6:0] PR   = 7'b0000010;
   localparam logic [6:0] TK   = 7'b0000001;

   typedef struct {
      string      name;
      logic [6:0] in;
      int         reps;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Expected output word: {play_enable, knockback, respawn, game_over, winner_L, score_L, score_R}
   function automatic logic [12:0] ex(logic pe, logic kb, logic rs, logic go, logic w,
                                      int sl, int sr);
      return {pe, kb, rs, go, w, 4'(sl), 4'(sr)};
   endfunction

   function automatic vec_t mk(string n, logic [6:0] in, int reps, logic [12:0] e);
      vec_t v;
      v.name = n;
      v.in   = in;
      v.reps = reps;
      v.exp  = e;
      return v;
   endfunction

   // Drive one cycle of inputs, then sample 1 time unit after the edge
   task automatic step(input logic [6:0] in);
      {reset, start, dead_L, dead_R, collision, pos_reset, frame_tick} = in;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [12:0] e);
      logic [12:0] obs;
      obs = {play_enable, knockback, respawn, game_over, winner_L, score_L, score_R};
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL %s: got pe=%b kb=%b rs=%b go=%b w=%b sL=%0d sR=%0d, want pe=%b kb=%b rs=%b go=%b w=%b sL=%0d sR=%0d",
                  nm, obs[12], obs[11], obs[10], obs[9], obs[8], obs[7:4], obs[3:0],
                  e[12], e[11], e[10], e[9], e[8], e[7:4], e[3:0]);
      end
   endtask

   initial begin
      // Table: basic death, double kill, clash, edge+death priority, ignored events
      vecs.push_back(mk("start",          ST,      1,   ex(1,0,1,0,0,0,0)));
      vecs.push_back(mk("play_idle",      NONE,    1,   ex(1,0,0,0,0,0,0)));
      vecs.push_back(mk("dead_r_held",    DR,      10,  ex(0,0,0,0,0,1,0)));
      vecs.push_back(mk("dw_ticks_119",   TK,      119, ex(0,0,0,0,0,1,0)));
      vecs.push_back(mk("dw_tick_120",    TK,      1,   ex(1,0,1,0,0,1,0)));
      vecs.push_back(mk("respawn_1cyc",   NONE,    1,   ex(1,0,0,0,0,1,0)));
      vecs.push_back(mk("double_kill",    DL | DR, 1,   ex(0,0,0,0,0,1,0)));
      vecs.push_back(mk("dk_ticks_119",   TK,      119, ex(0,0,0,0,0,1,0)));
      vecs.push_back(mk("dk_tick_120",    TK,      1,   ex(1,0,1,0,0,1,0)));
      vecs.push_back(mk("clash",          COL,     1,   ex(0,1,0,0,0,1,0)));
      vecs.push_back(mk("kb_ticks_7",     TK,      7,   ex(0,1,0,0,0,1,0)));
      vecs.push_back(mk("kb_tick_8",      TK,      1,   ex(1,0,0,0,0,1,0)));
      vecs.push_back(mk("kb_after",       NONE,    1,   ex(1,0,0,0,0,1,0)));
      vecs.push_back(mk("edge_and_dead_l", PR | DL, 1,  ex(0,0,0,0,0,1,0)));
      vecs.push_back(mk("round_reset_rs", NONE,    1,   ex(1,0,1,0,0,1,0)));
      vecs.push_back(mk("rr_after",       NONE,    1,   ex(1,0,0,0,0,1,0)));
      vecs.push_back(mk("clash2",         COL,     1,   ex(0,1,0,0,0,1,0)));
      vecs.push_back(mk("dead_l_in_kb",   DL,      1,   ex(0,1,0,0,0,1,0)));
      vecs.push_back(mk("kb2_ticks_7",    TK,      7,   ex(0,1,0,0,0,1,0)));
      vecs.push_back(mk("kb2_tick_8",     TK,      1,   ex(1,0,0,0,0,1,0)));
      vecs.push_back(mk("no_queued_death", NONE,   2,   ex(1,0,0,0,0,1,0)));

      // Reset state
      step(RST);
      step(RST);
      check("reset_state", ex(0,0,0,0,0,0,0));
      step(NONE);
      check("idle_after_reset", ex(0,0,0,0,0,0,0));
      step(DR);
      check("dead_in_idle_ignored", ex(0,0,0,0,0,0,0));
      step(NONE);

      foreach (vecs[i]) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            step(vecs[i].in);
            check(vecs[i].name, vecs[i].exp);
         end
      end

      // Kills 2..4 for the left player, each followed by a full respawn wait
      for (int k = 2; k <= 4; k++) begin
         step(DR);
         check($sformatf("kill_%0d", k), ex(0,0,0,0,0,k,0));
         step(NONE);
         for (int t = 0; t < 119; t++) step(TK);
         check($sformatf("kill_%0d_wait", k), ex(0,0,0,0,0,k,0));
         step(TK);
         check($sformatf("kill_%0d_respawn", k), ex(1,0,1,0,0,k,0));
      end

      // Fifth kill wins; later deaths are ignored; start restarts
      step(DR);
      check("win_left", ex(0,0,0,1,1,5,0));
      step(DL);
      check("go_dead_l_ignored", ex(0,0,0,1,1,5,0));
      step(DR);
      check("go_dead_r_ignored", ex(0,0,0,1,1,5,0));
      step(TK);
      check("go_holds", ex(0,0,0,1,1,5,0));
      step(ST);
      check("restart_from_go", ex(1,0,1,0,0,0,0));

      // Right player scores, then start mid-DEAD_WAIT restarts cleanly
      step(DL);
      check("right_scores", ex(0,0,0,0,0,0,1));
      step(ST);
      check("restart_from_dw", ex(1,0,1,0,0,0,0));
      step(NONE);
      check("restart_rs_1cyc", ex(1,0,0,0,0,0,0));

      // Reset at frame 50 of DEAD_WAIT overrides start and tick
      step(DR);
      check("dw_enter", ex(0,0,0,0,0,1,0));
      step(NONE);
      for (int t = 0; t < 50; t++) step(TK);
      check("dw_frame_50", ex(0,0,0,0,0,1,0));
      step(RST | ST | TK);
      check("reset_mid_dw", ex(0,0,0,0,0,0,0));
      step(NONE);
      check("idle_after_dw_reset", ex(0,0,0,0,0,0,0));

      // Reset mid-KNOCKBACK
      step(ST);
      check("start_again", ex(1,0,1,0,0,0,0));
      step(COL);
      check("kb_enter", ex(0,1,0,0,0,0,0));
      step(TK);
      step(TK);
      step(TK);
      check("kb_3_ticks", ex(0,1,0,0,0,0,0));
      step(RST | COL);
      check("reset_mid_kb", ex(0,0,0,0,0,0,0));
      step(NONE);
      check("idle_after_kb_reset", ex(0,0,0,0,0,0,0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/round_control.md
ROUND_CONTROL -- requirements
Module: round_control

Interface
REQ-001 SHALL have parameter RESPAWN_FRAMES, default 120, frames in DEAD_WAIT before respawn.
REQ-002 SHALL have parameter KNOCK_FRAMES, default 8, frames in KNOCKBACK after a sword clash.
REQ-003 SHALL have parameter WIN_SCORE, default 5, kills needed to win (1..15).
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-007 start  input  1  one-cycle pulse; begins or restarts a game.
REQ-008 dead_L, dead_R  input  1 each  level hit flags from the collision stage.
REQ-009 collision  input  1  level sword-clash flag.
REQ-010 pos_reset  input  1  level flag: a player reached a board edge.
REQ-011 play_enable  output  1  high only in PLAY; gates player movement.
REQ-012 knockback  output  1  high only in KNOCKBACK.
REQ-013 respawn  output  1  one-cycle pulse; player positions reload.
REQ-014 score_L, score_R  output  4 each  kill counters.
REQ-015 game_over  output  1  high only in GAME_OVER.
REQ-016 winner_L  output  1  valid while game_over; 1 = left player won.

Function
REQ-017 SHALL register dead_L, dead_R, collision, pos_reset each cycle and form rising-edge events (input high, registered copy low).
REQ-018 SHALL use states IDLE, PLAY, KNOCKBACK, DEAD_WAIT, ROUND_RESET, GAME_OVER; one-cycle transitions.
REQ-019 IDLE: on start -> clear both scores, pulse respawn, go to PLAY.
REQ-020 PLAY, event priority: pos_reset > death > collision; one event acted on per cycle; lower-priority events in the same cycle are discarded.
REQ-021 PLAY, pos_reset edge -> ROUND_RESET; the next cycle pulses respawn and returns to PLAY.
REQ-022 PLAY, dead_L edge only -> score_R+1; dead_R edge only -> score_L+1; both in the same cycle -> no score change (double kill); every death case -> DEAD_WAIT with frame counter cleared.
REQ-023 After a score increment, if either score equals WIN_SCORE -> GAME_OVER instead of DEAD_WAIT; winner_L = (score_L == WIN_SCORE).
REQ-024 DEAD_WAIT: count frame_tick pulses; when count reaches RESPAWN_FRAMES-1 and frame_tick is high -> pulse respawn, go to PLAY.
REQ-025 PLAY, collision edge -> KNOCKBACK; after KNOCK_FRAMES frame_tick pulses -> PLAY with no respawn.
REQ-026 Edge events arriving outside PLAY SHALL be ignored and not queued.
REQ-027 Frame counter SHALL be 8 bits, cleared on each state entry; it SHALL never wrap in DEAD_WAIT or KNOCKBACK.
REQ-028 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-029 start in any non-IDLE state SHALL clear scores, pulse respawn and enter PLAY (restart).
REQ-030 respawn SHALL be high for exactly one clk cycle per trigger.

Reset
REQ-031 reset SHALL force IDLE, scores 0, counter 0, edge registers 0, all outputs 0; it overrides start and all events in the same cycle, including mid-DEAD_WAIT or mid-KNOCKBACK.

Verification
REQ-032 reset, start, dead_R held high 10 cycles -> score_L=1 (one increment only), DEAD_WAIT, respawn pulse on the 120th frame_tick, play_enable back to 1.
REQ-033 dead_L and dead_R rising in the same cycle -> scores unchanged, DEAD_WAIT entered.
REQ-034 collision edge -> knockback=1 for exactly 8 frame_ticks; no respawn; scores unchanged.
REQ-035 pos_reset and dead_L rising in the same cycle -> ROUND_RESET then respawn pulse; score_R unchanged.
REQ-036 5 dead_R kills -> game_over=1, winner_L=1, score_L=5; further dead edges ignored; start -> scores 0, PLAY.
REQ-037 reset asserted at frame 50 of DEAD_WAIT -> next cycle IDLE, all outputs 0.
